// File: rtl/sig_period_meter_p16.sv
// Period and high-time meter for a 16-sample-per-clock parallel sample stream.
// Timestamps are in sample ticks: the time base advances by 16 per valid word.
module sig_period_meter_p16 #(
  parameter int unsigned MIN_PULSE     = 16,
  parameter int unsigned TIMEOUT_TICKS = 16777216
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] samples_in,
  input  logic        samples_valid,
  output logic [31:0] period_out,
  output logic [31:0] high_time_out,
  output logic        measure_valid,
  output logic        locked,
  output logic        timeout
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned TS_W   = 32;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_HIGH   = 2'd1;
  localparam logic [1:0] ST_LOW    = 2'd2;

  logic [WORD_W-1:0] word_q, word_d;
  logic              word_vld_q, word_vld_d;
  logic [TS_W-1:0]   base_q, base_d;
  logic              first_q, first_d;
  logic              prev_q, prev_d;
  logic [1:0]        state_q, state_d;
  logic [TS_W-1:0]   rise_ts_q, rise_ts_d;
  logic [TS_W-1:0]   fall_ts_q, fall_ts_d;
  logic [TS_W-1:0]   last_edge_q, last_edge_d;
  logic [TS_W-1:0]   period_q, period_d;
  logic [TS_W-1:0]   high_q, high_d;
  logic              meas_q, meas_d;
  logic              locked_q, locked_d;
  logic              timeout_q, timeout_d;

  logic [WORD_W:0]   ext;
  logic [WORD_W-1:0] rise_vec;
  logic [WORD_W-1:0] fall_vec;
  logic [WORD_W-1:0] want_vec;
  logic              hit;
  logic [TS_W-1:0]   hit_ts;

  // ext[0] is the sample just before bit 0; on the first word it mirrors bit 0 so no edge appears there
  assign ext      = {word_q, (first_q ? word_q[0] : prev_q)};
  assign rise_vec = ext[WORD_W:1] & ~ext[WORD_W-1:0];
  assign fall_vec = ~ext[WORD_W:1] & ext[WORD_W-1:0];
  assign want_vec = (state_q == ST_HIGH) ? fall_vec : rise_vec;

  // Lowest qualifying edge of the wanted polarity; scanning downward lets the lowest win
  always_comb begin
    hit    = 1'b0;
    hit_ts = '0;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (want_vec[i] &&
          ((state_q == ST_SEARCH) ||
           ((base_q + TS_W'(i) - last_edge_q) >= TS_W'(MIN_PULSE)))) begin
        hit    = 1'b1;
        hit_ts = base_q + TS_W'(i);
      end
    end
  end

  always_comb begin
    word_d      = samples_in;
    word_vld_d  = samples_valid;
    base_d      = base_q;
    first_d     = first_q;
    prev_d      = prev_q;
    state_d     = state_q;
    rise_ts_d   = rise_ts_q;
    fall_ts_d   = fall_ts_q;
    last_edge_d = last_edge_q;
    period_d    = period_q;
    high_d      = high_q;
    meas_d      = 1'b0;
    locked_d    = locked_q;
    timeout_d   = 1'b0;

    if (word_vld_q) begin
      base_d  = base_q + TS_W'(WORD_W);
      prev_d  = word_q[WORD_W-1];
      first_d = 1'b0;
      if (hit) begin
        last_edge_d = hit_ts;
        case (state_q)
          ST_SEARCH: begin
            rise_ts_d = hit_ts;
            state_d   = ST_HIGH;
          end
          ST_HIGH: begin
            fall_ts_d = hit_ts;
            state_d   = ST_LOW;
          end
          default: begin
            period_d  = hit_ts - rise_ts_q;
            high_d    = fall_ts_q - rise_ts_q;
            meas_d    = 1'b1;
            locked_d  = 1'b1;
            rise_ts_d = hit_ts;
            state_d   = ST_HIGH;
          end
        endcase
      end else if ((state_q != ST_SEARCH) &&
                   ((base_q + TS_W'(WORD_W) - last_edge_q) > TS_W'(TIMEOUT_TICKS))) begin
        // Measurement results are kept across a timeout
        state_d   = ST_SEARCH;
        locked_d  = 1'b0;
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_q      <= '0;
      word_vld_q  <= 1'b0;
      base_q      <= '0;
      first_q     <= 1'b1;
      prev_q      <= 1'b0;
      state_q     <= ST_SEARCH;
      rise_ts_q   <= '0;
      fall_ts_q   <= '0;
      last_edge_q <= '0;
      period_q    <= '0;
      high_q      <= '0;
      meas_q      <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      word_q      <= word_d;
      word_vld_q  <= word_vld_d;
      base_q      <= base_d;
      first_q     <= first_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      rise_ts_q   <= rise_ts_d;
      fall_ts_q   <= fall_ts_d;
      last_edge_q <= last_edge_d;
      period_q    <= period_d;
      high_q      <= high_d;
      meas_q      <= meas_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
    end
  end

  assign period_out    = period_q;
  assign high_time_out = high_q;
  assign measure_valid = meas_q;
  assign locked        = locked_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_sig_period_meter_p16.sv
// Bench for sig_period_meter_p16: waveforms are generated from period/high/offset parameters,
// expected measurements are derived from the rise times and scoreboarded against DUT pulses.
module tb_sig_period_meter_p16;

  localparam int unsigned TO_TICKS = 4096;
  localparam int unsigned MAX_U    = 32'hFFFF_FFFF;

  typedef struct {
    int          w;
    bit          to;
    logic [31:0] per;
    logic [31:0] hi;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] samples_in = '0;
  logic        samples_valid = 1'b0;
  logic [31:0] period_out, high_time_out;
  logic        measure_valid, locked, timeout;
  logic [31:0] g_period, g_high;
  logic        g_mv, g_locked, g_to;

  sig_period_meter_p16 #(.MIN_PULSE(16), .TIMEOUT_TICKS(TO_TICKS)) dut (
    .clock(clock), .reset(reset), .samples_in(samples_in), .samples_valid(samples_valid),
    .period_out(period_out), .high_time_out(high_time_out), .measure_valid(measure_valid),
    .locked(locked), .timeout(timeout)
  );

  // Long holdoff instance: swallows the glitch that the short-holdoff instance measures
  sig_period_meter_p16 #(.MIN_PULSE(256), .TIMEOUT_TICKS(TO_TICKS)) dut_g (
    .clock(clock), .reset(reset), .samples_in(samples_in), .samples_valid(samples_valid),
    .period_out(g_period), .high_time_out(g_high), .measure_valid(g_mv),
    .locked(g_locked), .timeout(g_to)
  );

  always #5 clock = ~clock;

  exp_t        sb[$];
  exp_t        sbg[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          widx = 0;
  int          rise_cnt = 0;
  int unsigned t = 0;
  int unsigned per = 1600, wave_hi = 800, r_tick = 0, s_tick = MAX_U;
  int unsigned hi_main = 800, hi_g = 800, f_tick = 0;
  bit          glitch = 1'b0, g_en = 1'b0, to_armed = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic lvl(input int unsigned ts);
    int unsigned ph;
    if (ts < r_tick || ts >= s_tick) return 1'b0;
    ph = (ts - r_tick) % per;
    if (glitch && ph >= 100 && ph < 103) return 1'b0;
    return ph < wave_hi;
  endfunction

  function automatic bit is_rise(input int unsigned ts);
    return ts >= r_tick && ts < s_tick && ((ts - r_tick) % per) == 0;
  endfunction

  // Outputs seen now belong to the word driven two calls earlier
  task automatic observe(input int k, input logic mv, input logic to, input logic lk,
                         input logic [31:0] p, input logic [31:0] h);
    exp_t  e;
    bit    have;
    string nm;
    have = 1'b0;
    nm   = (k == 0) ? "main" : "glitch";
    e    = '{0, 1'b0, 32'd0, 32'd0};
    if (k == 0 && sb.size() > 0 && sb[0].w == widx - 2) begin e = sb.pop_front(); have = 1'b1; end
    if (k == 1 && sbg.size() > 0 && sbg[0].w == widx - 2) begin e = sbg.pop_front(); have = 1'b1; end
    if (have || mv || to) begin
      check_eq($sformatf("%s_event_w%0d", nm, widx - 2), {30'd0, mv, to},
               have ? {30'd0, !e.to, e.to} : 32'd0);
      if (have && !e.to) begin
        check_eq($sformatf("%s_period", nm), p, e.per);
        check_eq($sformatf("%s_high", nm), h, e.hi);
        check_eq($sformatf("%s_locked_meas", nm), 32'(lk), 32'd1);
      end
      if (have && e.to) check_eq($sformatf("%s_locked_to", nm), 32'(lk), 32'd0);
    end
  endtask

  task automatic drive_word(input bit v);
    logic [15:0] d;
    exp_t        e;
    @(negedge clock);
    observe(0, measure_valid, timeout, locked, period_out, high_time_out);
    if (g_en) observe(1, g_mv, g_to, g_locked, g_period, g_high);
    d = 16'($urandom);
    if (v) begin
      for (int i = 0; i < 16; i++) begin
        d[i] = lvl(t + 32'(i));
        if (is_rise(t + 32'(i))) begin
          rise_cnt++;
          if (rise_cnt >= 2) begin
            e = '{widx, 1'b0, per, hi_main};
            sb.push_back(e);
            if (g_en) begin
              e.hi = hi_g;
              sbg.push_back(e);
            end
          end
        end
      end
      if (to_armed && (t + 16) > f_tick && (t + 16 - f_tick) > TO_TICKS) begin
        e = '{widx, 1'b1, 32'd0, 32'd0};
        sb.push_back(e);
        to_armed = 1'b0;
      end
      t += 16;
    end
    samples_in    = d;
    samples_valid = v;
    widx++;
  endtask

  task automatic run_to(input int unsigned limit, input bit gaps);
    while (t < limit) drive_word(gaps ? ($urandom_range(0, 99) >= 7) : 1'b1);
  endtask

  task automatic end_phase(input string tag);
    repeat (3) drive_word(1'b0);
    check_eq({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    if (g_en) check_eq({tag, "_sbg_empty"}, 32'(sbg.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset         = 1'b1;
    samples_valid = 1'b0;
    samples_in    = '0;
    @(negedge clock);
    check_eq("rst_period", period_out, 32'd0);
    check_eq("rst_high", high_time_out, 32'd0);
    check_eq("rst_mv", 32'(measure_valid), 32'd0);
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_timeout", 32'(timeout), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    sbg.delete();
    t        = 0;
    rise_cnt = 0;
    widx     = 0;
    to_armed = 1'b0;
  endtask

  task automatic set_wave(input int unsigned p, input int unsigned h, input int unsigned r);
    per     = p;
    wave_hi = h;
    r_tick  = r;
    s_tick  = MAX_U;
    glitch  = 1'b0;
    hi_main = h;
  endtask

  initial begin
    do_reset();

    // Ideal square wave, rise at start of word 2
    set_wave(1600, 800, 32);
    run_to(32 + 5 * 1600 + 16, 1'b0);
    end_phase("ideal");

    // Odd period walks the edge through every in-word position
    do_reset();
    set_wave(1603, 801, 5);
    run_to(5 + 20 * 1603 + 16, 1'b0);
    end_phase("odd");

    // Glitch 100 ticks after each rise
    do_reset();
    set_wave(1600, 800, 32);
    glitch  = 1'b1;
    g_en    = 1'b1;
    hi_main = 100;
    hi_g    = 800;
    run_to(32 + 5 * 1600 + 16, 1'b0);
    end_phase("glitch");
    g_en   = 1'b0;
    glitch = 1'b0;

    // Lock, then drop to constant low until timeout, then relock
    do_reset();
    set_wave(1600, 800, 32);
    s_tick   = 32 + 2 * 1600;
    f_tick   = 32 + 1600 + 800;
    to_armed = 1'b1;
    run_to(7000, 1'b0);
    check_eq("to_locked", 32'(locked), 32'd0);
    check_eq("to_period_hold", period_out, 32'd1600);
    check_eq("to_high_hold", high_time_out, 32'd800);
    r_tick   = t + 37;
    s_tick   = MAX_U;
    rise_cnt = 0;
    run_to(r_tick + 2 * 1600 + 32, 1'b0);
    end_phase("timeout");

    // Random valid gaps freeze the time base
    do_reset();
    set_wave(1600, 800, 32);
    run_to(32 + 5 * 1600 + 16, 1'b1);
    end_phase("gaps");

    // Constant high from the first word: no edge at all
    do_reset();
    set_wave(MAX_U, MAX_U, 0);
    run_to(1600, 1'b0);
    end_phase("const_high");
    check_eq("const_locked", 32'(locked), 32'd0);

    // Reset while in HIGH after locking
    do_reset();
    set_wave(1600, 800, 32);
    run_to(32 + 1600 + 160, 1'b0);
    drive_word(1'b1);
    drive_word(1'b1);
    check_eq("pre_rst_period", period_out, 32'd1600);
    check_eq("pre_rst_locked", 32'(locked), 32'd1);
    check_eq("pre_rst_sb_empty", 32'(sb.size()), 32'd0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
